// File: rtl/lane_scheduler.sv
// Four-lane ingress scheduler: per-lane FIFOs feeding one registered byte lane.
// Optional build macro LANE_SCHED_TDM_EN selects strict 4-slot TDM instead of work-conserving round-robin.
module lane_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  validEntrada0,
  input  logic                  validEntrada1,
  input  logic                  validEntrada2,
  input  logic                  validEntrada3,
  input  logic [DATA_WIDTH-1:0] Entrada0,
  input  logic [DATA_WIDTH-1:0] Entrada1,
  input  logic [DATA_WIDTH-1:0] Entrada2,
  input  logic [DATA_WIDTH-1:0] Entrada3,
  output logic                  readyEntrada0,
  output logic                  readyEntrada1,
  output logic                  readyEntrada2,
  output logic                  readyEntrada3,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic [1:0]            laneSalida,
  input  logic                  readySalida,
  output logic [3:0]            errorOverflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_r [4][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r [4];
  logic [PTR_W-1:0]      rd_ptr_r [4];
  logic [CNT_W-1:0]      count_r [4];
  logic [DATA_WIDTH-1:0] in_data_s [4];
  logic [3:0]            in_valid_s;
  logic [3:0]            in_ready_s;
  logic [3:0]            push_s;
  logic [3:0]            pop_s;
  logic [3:0]            nonempty_s;
  logic [1:0]            ptr_r;
  logic [1:0]            ptr_next_s;
  logic [1:0]            grant_s;
  logic [1:0]            cand_s;
  logic                  grant_valid_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign readyEntrada0 = in_ready_s[0];
  assign readyEntrada1 = in_ready_s[1];
  assign readyEntrada2 = in_ready_s[2];
  assign readyEntrada3 = in_ready_s[3];

  // Gather lane inputs; readiness depends only on registered counts and reset.
  always_comb begin
    in_valid_s   = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};
    in_data_s[0] = Entrada0;
    in_data_s[1] = Entrada1;
    in_data_s[2] = Entrada2;
    in_data_s[3] = Entrada3;
    for (int i = 0; i < 4; i++) begin
      in_ready_s[i] = !reset && (count_r[i] != CNT_W'(FIFO_DEPTH));
      nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
    end
    push_s = in_valid_s & in_ready_s;
    load_s = !validSalida || readySalida;
  end

  // Lane selection for the next output beat.
  always_comb begin
    grant_s       = ptr_r;
    grant_valid_s = 1'b0;
    ptr_next_s    = ptr_r;
    cand_s        = ptr_r;
`ifdef LANE_SCHED_TDM_EN
    grant_valid_s = nonempty_s[ptr_r];
    ptr_next_s    = ptr_r + 2'd1;
`else
    // Walk from farthest to nearest so the lane closest to ptr wins.
    for (int k = 3; k >= 0; k--) begin
      cand_s = ptr_r + 2'(k);
      if (nonempty_s[cand_s]) begin
        grant_s       = cand_s;
        grant_valid_s = 1'b1;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    if (grant_valid_s) begin
      ptr_next_s = grant_s + 2'd1;
    end else begin
      ptr_next_s = ptr_r;
    end
`endif
    if (load_s && grant_valid_s) begin
      pop_s = 4'b0001 << grant_s;
    end else begin
      pop_s = 4'b0000;
    end
    head_s = mem_r[grant_s][rd_ptr_r[grant_s]];
  end

  // FIFO storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      errorOverflow <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      errorOverflow <= errorOverflow | (in_valid_s & ~in_ready_s);
      for (int i = 0; i < 4; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
          2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Registered output beat and round-robin pointer; frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r       <= 2'd0;
      Salida      <= {DATA_WIDTH{1'b0}};
      laneSalida  <= 2'd0;
      validSalida <= 1'b0;
    end else if (load_s) begin
      ptr_r <= ptr_next_s;
      if (grant_valid_s) begin
        Salida      <= head_s;
        laneSalida  <= grant_s;
        validSalida <= 1'b1;
      end else begin
        validSalida <= 1'b0;
`ifdef LANE_SCHED_TDM_EN
        laneSalida  <= grant_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed self-checking bench for lane_scheduler in its default (work-conserving) build.
`timescale 1ns/1ps
module tb_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  logic [3:0] in_ready;
  logic [7:0] salida;
  logic       valid_salida;
  logic [1:0] lane_salida;
  logic       ready_salida;
  logic [3:0] error_overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_data [5];
  logic [1:0] exp_lane [5];

  always #5 clk = ~clk;

  lane_scheduler #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .validEntrada0(in_valid[0]), .validEntrada1(in_valid[1]),
    .validEntrada2(in_valid[2]), .validEntrada3(in_valid[3]),
    .Entrada0(in_data[0]), .Entrada1(in_data[1]),
    .Entrada2(in_data[2]), .Entrada3(in_data[3]),
    .readyEntrada0(in_ready[0]), .readyEntrada1(in_ready[1]),
    .readyEntrada2(in_ready[2]), .readyEntrada3(in_ready[3]),
    .Salida(salida), .validSalida(valid_salida), .laneSalida(lane_salida),
    .readySalida(ready_salida), .errorOverflow(error_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 4'b0000;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  // Lane0={00,01}, lanes1..3={10},{20},{30}; 0x00 ends up held on the output stage.
  task automatic preload();
    ready_salida = 1'b0;
    in_valid = 4'b1111;
    in_data[0] = 8'h00; in_data[1] = 8'h10; in_data[2] = 8'h20; in_data[3] = 8'h30;
    tick();
    check_eq("preload_empty_out", {31'd0, valid_salida}, 32'd0);
    in_valid = 4'b0001;
    in_data[0] = 8'h01;
    tick();
    in_valid = 4'b0000;
    check_eq("preload_first", {23'd0, valid_salida, lane_salida, salida}, {23'd0, 1'b1, 2'd0, 8'h00});
  endtask

  initial begin
    reset = 1'b1;
    ready_salida = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 8'hEE;

    // Reset with lanes offering data: nothing may be pushed or flagged.
    tick();
    check_eq("rst_ready_low", {28'd0, in_ready}, 32'h0);
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    check_eq("rst_valid", {31'd0, valid_salida}, 32'd0);
    check_eq("rst_salida", {24'd0, salida}, 32'h0);
    check_eq("rst_lane", {30'd0, lane_salida}, 32'd0);
    check_eq("rst_ready_high", {28'd0, in_ready}, 32'hF);
    check_eq("rst_overflow", {28'd0, error_overflow}, 32'h0);
    tick();
    check_eq("rst_no_stale", {31'd0, valid_salida}, 32'd0);

    // Single lane 2: one-cycle latency, one beat per cycle.
    do_reset();
    ready_salida = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3) ? 4'b0100 : 4'b0000;
      in_data[2] = 8'hA1 + 8'(c);
      tick();
      if (c >= 1 && c <= 3) begin
        check_eq($sformatf("single_beat%0d", c),
                 {23'd0, valid_salida, lane_salida, salida},
                 {23'd0, 1'b1, 2'd2, 8'hA0 + 8'(c)});
      end else begin
        check_eq($sformatf("single_idle%0d", c), {31'd0, valid_salida}, 32'd0);
      end
    end
    check_eq("single_hold", {24'd0, salida}, 32'hA3);

    // Round-robin fairness.
    do_reset();
    preload();
    ready_salida = 1'b1;
    exp_data[0] = 8'h10; exp_lane[0] = 2'd1;
    exp_data[1] = 8'h20; exp_lane[1] = 2'd2;
    exp_data[2] = 8'h30; exp_lane[2] = 2'd3;
    exp_data[3] = 8'h01; exp_lane[3] = 2'd0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_eq($sformatf("rr_beat%0d", n),
               {23'd0, valid_salida, lane_salida, salida},
               {23'd0, 1'b1, exp_lane[n], exp_data[n]});
    end
    tick();
    check_eq("rr_drained", {31'd0, valid_salida}, 32'd0);

    // Backpressure: 0x10/lane1 frozen for 5 cycles, then lane 2 follows.
    do_reset();
    preload();
    ready_salida = 1'b1;
    tick();
    ready_salida = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check_eq($sformatf("bp_stall%0d", n),
               {23'd0, valid_salida, lane_salida, salida},
               {23'd0, 1'b1, 2'd1, 8'h10});
    end
    ready_salida = 1'b1;
    tick();
    check_eq("bp_resume", {23'd0, valid_salida, lane_salida, salida}, {23'd0, 1'b1, 2'd2, 8'h20});

    // Fill lane 3 under backpressure; a full lane refuses even when popped.
    do_reset();
    ready_salida = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 4'b1000;
      in_data[3] = 8'h50 + 8'(n);
      tick();
      check_eq($sformatf("full_ready%0d", n), {31'd0, in_ready[3]}, (n == 4) ? 32'd0 : 32'd1);
    end
    check_eq("full_no_ovf", {28'd0, error_overflow}, 32'h0);
    in_data[3] = 8'h55;
    ready_salida = 1'b1;
    tick();
    in_valid = 4'b0000;
    check_eq("ovf_set", {28'd0, error_overflow}, 32'h8);
    check_eq("ovf_pop", {24'd0, salida}, 32'h51);
    for (int n = 2; n < 5; n++) begin
      tick();
      check_eq($sformatf("ovf_drain%0d", n), {23'd0, valid_salida, lane_salida, salida},
               {23'd0, 1'b1, 2'd3, 8'h50 + 8'(n)});
    end
    tick();
    check_eq("ovf_dropped", {31'd0, valid_salida}, 32'd0);
    check_eq("ovf_sticky", {28'd0, error_overflow}, 32'h8);
    check_eq("ovf_ready_back", {31'd0, in_ready[3]}, 32'd1);

    // Reset mid-operation clears FIFOs, output stage, flags and ptr.
    preload();
    reset = 1'b1;
    tick();
    check_eq("mid_rst_out", {23'd0, valid_salida, lane_salida, salida}, 32'h0);
    check_eq("mid_rst_ready", {28'd0, in_ready}, 32'h0);
    check_eq("mid_rst_ovf", {28'd0, error_overflow}, 32'h0);
    reset = 1'b0;
    ready_salida = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq($sformatf("mid_rst_nostale%0d", n), {31'd0, valid_salida}, 32'd0);
    end
    in_valid = 4'b1001;
    in_data[0] = 8'hC0;
    in_data[3] = 8'hC3;
    tick();
    in_valid = 4'b0000;
    tick();
    check_eq("mid_rst_ptr0", {23'd0, valid_salida, lane_salida, salida}, {23'd0, 1'b1, 2'd0, 8'hC0});
    tick();
    check_eq("mid_rst_ptr1", {23'd0, valid_salida, lane_salida, salida}, {23'd0, 1'b1, 2'd3, 8'hC3});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
